// File: rtl/uart_pkg.sv
// Shared constants and reset-divisor helpers for the UART baud path.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package uart_pkg;

    localparam int CLK_HZ_DEF     = 62_000_000;
    localparam int BAUD_DEF       = 115200;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DIV_W_DEF      = 16;
    localparam int FRAC_W_DEF     = 4;

    // Smallest usable integer divisor; anything lower is clamped to this.
    localparam int MIN_DIV = 2;

    // Clocks per rx tick in fixed point (FRAC_W fractional bits), rounded to
    // nearest. Deriving int/frac from one rounded total lets a fraction that
    // rounds up to 1.0 carry cleanly into the integer part.
    function automatic longint def_total(input longint clk_hz, input longint baud,
                                         input longint os, input int frac_w);
        longint d;
        d = baud * os;
        return ((clk_hz << (frac_w + 1)) + d) / (2 * d);
    endfunction

    function automatic longint def_int(input longint clk_hz, input longint baud,
                                       input longint os, input int frac_w);
        return def_total(clk_hz, baud, os, frac_w) >> frac_w;
    endfunction

    function automatic longint def_frac(input longint clk_hz, input longint baud,
                                        input longint os, input int frac_w);
        return def_total(clk_hz, baud, os, frac_w) & ((longint'(1) << frac_w) - 1);
    endfunction

endpackage

// File: rtl/frac_divider.sv
// Fractional clock divider: one registered tick per (div_int + carry) clocks, plus shadowed divisor reload.
// Latency: o_tick is high the cycle after the period-end edge; o_period_end is the combinational last-cycle flag.
// Backpressure: none; i_en=0 clears the count/accumulator and applies any pending divisor at once.
// Ports: i_clk/i_rst (sync, active-high), i_en, i_cfg_wr/i_cfg_div_int/i_cfg_div_frac config strobe,
//        o_cfg_pending (shadow waiting), o_period_end (current cycle ends a period), o_tick (registered).
module frac_divider
    import uart_pkg::*;
#(
    parameter int                DIV_W    = DIV_W_DEF,
    parameter int                FRAC_W   = FRAC_W_DEF,
    parameter logic [DIV_W-1:0]  DEF_INT  = DIV_W'(MIN_DIV),
    parameter logic [FRAC_W-1:0] DEF_FRAC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_cfg_wr,
    input  logic [DIV_W-1:0]  i_cfg_div_int,
    input  logic [FRAC_W-1:0] i_cfg_div_frac,
    output logic              o_cfg_pending,
    output logic              o_period_end,
    output logic              o_tick
);

    logic [DIV_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic [DIV_W-1:0]  r_div_int;
    logic [FRAC_W-1:0] r_div_frac;
    logic [DIV_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_pending;
    logic              r_tick;

    logic [FRAC_W:0]   w_sum;
    logic [DIV_W:0]    w_len_m1;
    logic              w_last;
    logic              w_apply;
    logic [DIV_W-1:0]  w_wr_int;

    // Carry out of the fractional accumulator stretches this period by one clock.
    assign w_sum    = {1'b0, r_acc} + {1'b0, r_div_frac};
    assign w_len_m1 = {1'b0, r_div_int} - (DIV_W+1)'(1) + (DIV_W+1)'(w_sum[FRAC_W]);
    assign w_last   = ({1'b0, r_cnt} == w_len_m1);

    // Divisor changes only land between periods; while disabled every cycle counts as "between".
    assign w_apply  = !i_en || w_last;
    assign w_wr_int = (i_cfg_div_int < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_cfg_div_int;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_div_int  <= DEF_INT;
            r_div_frac <= DEF_FRAC;
            r_sh_int   <= DEF_INT;
            r_sh_frac  <= DEF_FRAC;
            r_pending  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= i_en && w_last;

            if (!i_en) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_last) begin
                r_cnt <= '0;
                r_acc <= w_sum[FRAC_W-1:0];
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end

            if (w_apply) begin
                // A write arriving on the boundary itself wins over an older shadow.
                if (i_cfg_wr) begin
                    r_div_int  <= w_wr_int;
                    r_div_frac <= i_cfg_div_frac;
                end else if (r_pending) begin
                    r_div_int  <= r_sh_int;
                    r_div_frac <= r_sh_frac;
                end
                r_pending <= 1'b0;
            end else if (i_cfg_wr) begin
                r_sh_int  <= w_wr_int;
                r_sh_frac <= i_cfg_div_frac;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_cfg_pending = r_pending;
    assign o_period_end  = i_en && w_last;
    assign o_tick        = r_tick;

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: rx_tick at OVERSAMPLE x baud, tx_tick on every OVERSAMPLE-th rx_tick.
// Latency: all outputs registered; a tick is high the cycle after its period-end edge.
// Backpressure: none; i_en=0 holds counters cleared and ticks low, config path stays live.
// Ports: i_clk/i_rst (sync, active-high), i_en, i_cfg_wr/i_cfg_div_int/i_cfg_div_frac,
//        o_cfg_pending, o_cfg_err (clamped-divisor pulse), o_rx_tick, o_tx_tick.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int BAUD       = BAUD_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int FRAC_W     = FRAC_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_cfg_wr,
    input  logic [DIV_W-1:0]  i_cfg_div_int,
    input  logic [FRAC_W-1:0] i_cfg_div_frac,
    output logic              o_cfg_pending,
    output logic              o_cfg_err,
    output logic              o_rx_tick,
    output logic              o_tx_tick
);

    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(def_int(CLK_HZ, BAUD, OVERSAMPLE, FRAC_W));
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(def_frac(CLK_HZ, BAUD, OVERSAMPLE, FRAC_W));
    localparam int                SUB_W    = $clog2(OVERSAMPLE);

    logic             w_period_end;
    logic             w_rx_tick;
    logic             w_pending;
    logic [SUB_W-1:0] r_sub;
    logic             r_tx_tick;
    logic             r_cfg_err;

    frac_divider #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .DEF_INT  (DEF_INT),
        .DEF_FRAC (DEF_FRAC)
    ) u_frac_divider (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_en           (i_en),
        .i_cfg_wr       (i_cfg_wr),
        .i_cfg_div_int  (i_cfg_div_int),
        .i_cfg_div_frac (i_cfg_div_frac),
        .o_cfg_pending  (w_pending),
        .o_period_end   (w_period_end),
        .o_tick         (w_rx_tick)
    );

    // The sub counter is never touched by divisor reloads, so TX bit phase survives a rate change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sub     <= '0;
            r_tx_tick <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= i_cfg_wr && (i_cfg_div_int < DIV_W'(MIN_DIV));
            r_tx_tick <= w_period_end && (r_sub == '1);
            if (!i_en) begin
                r_sub <= '0;
            end else if (w_period_end) begin
                r_sub <= r_sub + SUB_W'(1);
            end
        end
    end

    assign o_cfg_pending = w_pending;
    assign o_cfg_err     = r_cfg_err;
    assign o_rx_tick     = w_rx_tick;
    assign o_tx_tick     = r_tx_tick;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at default parameters (33 + 10/16 clocks per rx tick).
// Latency: expected tick edges are hand-derived edge numbers counted from reset/enable release.
// Backpressure: n/a.
module tb_baud_tick_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_wr;
    logic [15:0] cfg_int;
    logic [3:0]  cfg_frac;
    logic        pending;
    logic        err;
    logic        rx;
    logic        tx;

    int cyc;
    int n_chk;
    int n_bad;

    always #5 clk = ~clk;

    baud_tick_gen dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .i_cfg_wr       (cfg_wr),
        .i_cfg_div_int  (cfg_int),
        .i_cfg_div_frac (cfg_frac),
        .o_cfg_pending  (pending),
        .o_cfg_err      (err),
        .o_rx_tick      (rx),
        .o_tx_tick      (tx)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge, inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    // Advance to the next rx (or tx) tick; returns its edge number or -1 on timeout.
    task automatic wait_evt(input bit want_tx, output int e);
        e = -1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (want_tx ? tx : rx) begin
                e = cyc;
                break;
            end
        end
    endtask

    int e;
    int rx_n, tx_n, orphan, last_tx, rx16, quiet;
    int rxe[4];
    int txe[2];

    initial begin
        n_chk = 0; n_bad = 0; cyc = 0;
        rst = 1'b1; en = 1'b0; cfg_wr = 1'b0; cfg_int = '0; cfg_frac = '0;
        step(); step();
        chk("rst_rx", rx, 0);
        chk("rst_tx", tx, 0);
        chk("rst_pending", pending, 0);
        chk("rst_err", err, 0);

        // Release reset with en=1; the next edge is edge 1.
        rst = 1'b0; en = 1'b1; cyc = 0;
        rx_n = 0; tx_n = 0; orphan = 0; last_tx = -1; rx16 = -1;
        foreach (rxe[i]) rxe[i] = -1;
        foreach (txe[i]) txe[i] = -1;
        for (int i = 0; i < 53800; i++) begin
            step();
            if (rx) begin
                if (rx_n < 4) rxe[rx_n] = cyc;
                if (rx_n == 15) rx16 = cyc;
                rx_n++;
            end
            if (tx) begin
                if (tx_n < 2) txe[tx_n] = cyc;
                tx_n++;
                last_tx = cyc;
                if (!rx) orphan++;
            end
        end
        chk("rx_1st", rxe[0], 33);
        chk("rx_2nd", rxe[1], 67);
        chk("rx_3rd", rxe[2], 100);
        chk("rx_4th", rxe[3], 134);
        chk("rx_16th", rx16, 538);
        chk("tx_1st", txe[0], 538);
        chk("tx_2nd", txe[1], 1076);
        chk("long_rx_count", rx_n, 1600);
        chk("long_tx_count", tx_n, 100);
        chk("long_last_tx", last_tx, 53800);
        chk("tx_without_rx", orphan, 0);

        // Reload to 8/0 mid-period; current 33-clk period (started at 53800) must finish first.
        run_to(53805);
        cfg_wr = 1'b1; cfg_int = 16'd8; cfg_frac = 4'd0;
        step();
        cfg_wr = 1'b0;
        chk("reload_pending_set", pending, 1);
        run_to(53832);
        chk("reload_pending_hold", pending, 1);
        chk("reload_no_early_rx", rx, 0);
        step();
        chk("reload_old_period_end", rx, 1);
        chk("reload_pending_clr", pending, 0);
        wait_evt(0, e); chk("reload_rx_p8_a", e, 53841);
        wait_evt(0, e); chk("reload_rx_p8_b", e, 53849);
        // sub was 1 after the 53833 tick: 15 more ticks of 8 to the wrap.
        wait_evt(1, e); chk("reload_tx_phase", e, 53953);
        wait_evt(1, e); chk("reload_tx_spacing", e, 54081);

        // Write landing exactly on the 54089 period-end edge takes effect immediately.
        run_to(54088);
        cfg_wr = 1'b1; cfg_int = 16'd5; cfg_frac = 4'd0;
        step();
        cfg_wr = 1'b0;
        chk("edge_wr_rx", rx, 1);
        chk("edge_wr_pending", pending, 0);
        wait_evt(0, e); chk("edge_wr_p5_a", e, 54094);
        chk("edge_wr_pending_after", pending, 0);
        wait_evt(0, e); chk("edge_wr_p5_b", e, 54099);

        // int=1 is clamped to 2 and flagged.
        run_to(54101);
        cfg_wr = 1'b1; cfg_int = 16'd1; cfg_frac = 4'd0;
        step();
        cfg_wr = 1'b0;
        chk("clamp1_err", err, 1);
        chk("clamp1_pending", pending, 1);
        step();
        chk("clamp1_err_pulse", err, 0);
        wait_evt(0, e); chk("clamp1_old_end", e, 54104);
        wait_evt(0, e); chk("clamp1_p2_a", e, 54106);
        wait_evt(0, e); chk("clamp1_p2_b", e, 54108);
        cfg_wr = 1'b1; cfg_int = 16'd0; cfg_frac = 4'd0;
        step();
        cfg_wr = 1'b0;
        chk("clamp0_err", err, 1);
        wait_evt(0, e); chk("clamp0_p2_a", e, 54110);
        wait_evt(0, e); chk("clamp0_p2_b", e, 54112);

        // Reset with a pending shadow: shadow discarded, defaults back.
        cfg_wr = 1'b1; cfg_int = 16'd8; cfg_frac = 4'd0;
        step();
        cfg_wr = 1'b0;
        chk("rst_mid_pending_set", pending, 1);
        rst = 1'b1;
        step();
        chk("rst_mid_pending_clr", pending, 0);
        chk("rst_mid_rx", rx, 0);
        rst = 1'b0;
        wait_evt(0, e); chk("rst_mid_def_a", e, 54147);
        wait_evt(0, e); chk("rst_mid_def_b", e, 54181);

        // en low for 50 clocks mid-period; a tick would otherwise fall at 54214.
        run_to(54191);
        en = 1'b0;
        step();
        chk("en_low_rx", rx, 0);
        quiet = 0;
        for (int i = 0; i < 49; i++) begin
            step();
            if (rx || tx) quiet++;
        end
        chk("en_low_ticks", quiet, 0);
        en = 1'b1;
        wait_evt(0, e); chk("reen_rx_a", e, 54274);
        wait_evt(0, e); chk("reen_rx_b", e, 54308);
        wait_evt(1, e); chk("reen_tx", e, 54779);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
